pc_fetch_unit: RTL

Instruction-fetch front end of the processor: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions for decode. It is the consumer of the branch-select decision. A one-cycle `pc_mux` pulse with `branch_target` redirects fetch, flushes buffered instructions and discards in-flight responses. Sits between instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_e : IDLE (post-reset bubble), FETCH (normal), DRAIN (discarding
//                   responses that belong to a redirected-away path)
//   fetch_entry_t : {pc, instr} as held in the fetch FIFOs
//   FETCH_DEPTH   : fetch credits, i.e. in-flight plus buffered instructions
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          FETCH_DEPTH = 2;
  localparam int          CNT_W       = $clog2(FETCH_DEPTH + 1);
  // Width of the pc field in fetch_entry_t; the fetch unit's XLEN must not exceed it.
  localparam int          PC_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response channel plus the
// fetch->decode channel.
//   master : the fetch unit (drives requests and the decode-side instruction)
//   slave  : memory + decode side
interface pc_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: FETCH_DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset (storage resets to RST_VAL)
//   push, din  : write (accepted when not full, or full with a same-cycle pop)
//   pop        : read-advance (ignored when empty)
//   clear      : empty the FIFO; wins over push and pop in the same cycle
//   dout       : head entry (stale when count == 0)
//   count      : current occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter fetch_entry_t RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     din,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count
);
  // Pointers wrap by overflow, so FETCH_DEPTH is kept a power of two.
  localparam int PW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

  fetch_entry_t  mem [FETCH_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(FETCH_DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) mem[i] <= RST_VAL;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end. Owns the PC, issues word fetches,
// buffers returned instructions for decode, and handles branch redirects.
//   clk, rst_n          : clock, async active-low reset
//   pc_mux, branch_target: one-cycle redirect pulse and its target (bits [1:0] ignored)
//   bus (master)        : imem request/response channel and decode channel
//   flush_o             : registered pulse, high the cycle after an accepted redirect
// Optional (FETCH_PERF_EN defined): perf_redirects / perf_dropped, saturating
// counts of accepted redirects and discarded responses.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_mux,
  input  logic [XLEN-1:0] branch_target,
  pc_fetch_unit_if.master bus,
  output logic            flush_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_dropped
`endif
);
  localparam int           SUM_W  = CNT_W + 1;
  localparam fetch_entry_t DQ_RST = '{pc: PC_W'(RESET_PC), instr: NOP_INSTR};

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] drop_cnt, oq_cnt, dq_cnt, oq_next;
  fetch_entry_t     oq_din, oq_head, dq_din, dq_head;
  logic             req_valid, req_hs, redirect, credit_ok, oq_pop;

  assign redirect = pc_mux && (state_q != IDLE);
  // Credits cover buffered entries too, so a stalled decode throttles fetch.
  // With a 1-cycle memory the credit loop is 3 cycles deep for 2 credits.
  assign credit_ok = (SUM_W'(oq_cnt) + SUM_W'(dq_cnt)) < SUM_W'(FETCH_DEPTH);
  assign req_hs    = req_valid && bus.imem_req_ready;
  assign oq_pop    = bus.imem_rsp_valid && (oq_cnt != '0);
  // In-flight count once this cycle's request and response handshakes land.
  assign oq_next   = oq_cnt + CNT_W'(req_hs) - CNT_W'(oq_pop);

  // Outstanding-request PCs: the head tags each returning response.
  assign oq_din = '{pc: PC_W'(fetch_pc), instr: NOP_INSTR};

  fetch_fifo u_oq (
    .clk(clk), .rst_n(rst_n), .push(req_hs), .din(oq_din), .pop(oq_pop),
    .clear(1'b0), .dout(oq_head), .count(oq_cnt)
  );

  always_comb begin
    dq_din       = oq_head;
    dq_din.instr = bus.imem_rsp_data;
  end

  // Decode buffer: a redirect clears it and suppresses the head pop.
  fetch_fifo #(.RST_VAL(DQ_RST)) u_dq (
    .clk(clk), .rst_n(rst_n),
    .push(bus.imem_rsp_valid && (state_q == FETCH) && (drop_cnt == '0)),
    .din(dq_din), .pop(bus.if_ready && !redirect), .clear(redirect),
    .dout(dq_head), .count(dq_cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (redirect) state_d = (oq_next != '0) ? DRAIN : FETCH;
      DRAIN: begin
        if (redirect)
          state_d = (oq_next != '0) ? DRAIN : FETCH;
        else if (bus.imem_rsp_valid && (drop_cnt == CNT_W'(1)))
          state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request depends only on state and counters.
  always_comb begin
    req_valid = 1'b0;
    if ((state_q == FETCH) && credit_ok) req_valid = 1'b1;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc;
  assign bus.if_valid       = (dq_cnt != '0);
  assign bus.if_instr       = dq_head.instr;
  assign bus.if_pc          = XLEN'(dq_head.pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      flush_o  <= 1'b0;
    end else begin
      flush_o <= redirect;
      if (redirect) begin
        fetch_pc <= {branch_target[XLEN-1:2], 2'b00};
        drop_cnt <= oq_next;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
        if ((state_q == DRAIN) && bus.imem_rsp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_rsp;
  // Every response seen while draining or on a redirect cycle is discarded.
  assign drop_rsp = bus.imem_rsp_valid && (redirect || (state_q == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects <= '0;
      perf_dropped   <= '0;
    end else begin
      if (redirect && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
      if (drop_rsp && (perf_dropped != '1))   perf_dropped   <= perf_dropped + 32'd1;
    end
  end
`endif
endmodule
